// File: rtl/bcd_counter_n_if.sv
// bcd_counter_n_if: control/data bundle for the N-digit BCD counter.
// The master side (controller/testbench) drives enable, direction and load;
// the slave side (the counter) returns the count, ripple enables and flags.
// ena is at least one bit wide so the bundle stays legal when DIGITS == 1.
interface bcd_counter_n_if #(
    parameter int DIGITS = 4
);
    localparam int ENA_W = (DIGITS > 1) ? (DIGITS - 1) : 1;

    logic                  en;
    logic                  up_dn;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   q;
    logic [ENA_W-1:0]      ena;
    logic                  tc;
    logic                  wrap;
    logic                  load_err;

    modport master (
        output en, up_dn, load, load_val,
        input  q, ena, tc, wrap, load_err
    );

    modport slave (
        input  en, up_dn, load, load_val,
        output q, ena, tc, wrap, load_err
    );
endinterface

// File: rtl/bcd_counter_n.sv
// bcd_counter_n: parametrised N-digit synchronous BCD up/down counter with
// count enable, validated parallel load, terminal count and wrap/load-error
// pulses. Per-digit step enables are exported on ena for cascading.
// Optional feature macro: BCD_SATURATE_EN -- when defined the counter holds at
// all-9 (up) / all-0 (down) instead of wrapping, and wrap is tied low.
module bcd_counter_n #(
    parameter int                  DIGITS    = 4,
    parameter logic [4*DIGITS-1:0] RESET_VAL = '0
) (
    input  logic               clk,
    input  logic               reset,
    bcd_counter_n_if.slave     bus
);

    localparam int W = 4 * DIGITS;

    // All nibbles must be decimal digits for a load to be accepted.
    function automatic logic bcd_valid(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            ok = ok & (v[4*i +: 4] <= 4'd9);
        end
        return ok;
    endfunction

    // One decimal step of a single digit in the requested direction.
    function automatic logic [3:0] digit_step(input logic [3:0] d, input logic up);
        logic [3:0] n;
        if (up) begin
            n = (d == 4'd9) ? 4'd0 : (d + 4'd1);
        end else begin
            n = (d == 4'd0) ? 4'd9 : (d - 4'd1);
        end
        return n;
    endfunction

    logic [W-1:0]      r_q;
    logic              r_load_err;
    logic [DIGITS-1:0] w_step;
    logic [W-1:0]      w_q_next;
    logic              w_tc;
    logic              w_go;
    logic              w_load_ok;

    assign w_load_ok = bcd_valid(bus.load_val);

    // Carry/borrow chain: which digits step this cycle, next count and terminal count.
    always_comb begin
        logic run9;
        logic run0;
        logic [DIGITS-1:0] below9;
        logic [DIGITS-1:0] below0;
        run9     = 1'b1;
        run0     = 1'b1;
        below9   = '0;
        below0   = '0;
        w_step   = '0;
        w_q_next = r_q;
        for (int i = 0; i < DIGITS; i++) begin
            below9[i] = run9;
            below0[i] = run0;
            run9      = run9 & (r_q[4*i +: 4] == 4'd9);
            run0      = run0 & (r_q[4*i +: 4] == 4'd0);
        end
        w_tc = bus.up_dn ? run9 : run0;
`ifdef BCD_SATURATE_EN
        w_go = bus.en & ~bus.load & ~reset & ~w_tc;
`else
        w_go = bus.en & ~bus.load & ~reset;
`endif
        for (int i = 0; i < DIGITS; i++) begin
            w_step[i] = w_go & (bus.up_dn ? below9[i] : below0[i]);
            if (w_step[i]) begin
                w_q_next[4*i +: 4] = digit_step(r_q[4*i +: 4], bus.up_dn);
            end else begin
                w_q_next[4*i +: 4] = r_q[4*i +: 4];
            end
        end
    end

`ifdef BCD_SATURATE_EN
    // Count/load register with error pulse; saturating build never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q        <= RESET_VAL;
            r_load_err <= 1'b0;
        end else if (bus.load) begin
            if (w_load_ok) begin
                r_q <= bus.load_val;
            end else begin
                r_q <= r_q;
            end
            r_load_err <= ~w_load_ok;
        end else begin
            r_q        <= w_q_next;
            r_load_err <= 1'b0;
        end
    end

    assign bus.wrap = 1'b0;
`else
    logic r_wrap;

    // Count/load register with wrap and load-error pulses; tc while counting means a wrap lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q        <= RESET_VAL;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else if (bus.load) begin
            if (w_load_ok) begin
                r_q <= bus.load_val;
            end else begin
                r_q <= r_q;
            end
            r_wrap     <= 1'b0;
            r_load_err <= ~w_load_ok;
        end else if (bus.en) begin
            r_q        <= w_q_next;
            r_wrap     <= w_tc;
            r_load_err <= 1'b0;
        end else begin
            r_q        <= r_q;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end
    end

    assign bus.wrap = r_wrap;
`endif

    assign bus.q        = r_q;
    assign bus.tc       = w_tc;
    assign bus.load_err = r_load_err;

    generate
        if (DIGITS > 1) begin : g_ena
            assign bus.ena = w_step[DIGITS-1:1];
        end else begin : g_no_ena
            assign bus.ena = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_bcd_counter_n.sv
// tb_bcd_counter_n: directed + randomized check of bcd_counter_n (DIGITS=4,
// RESET_VAL=0500) against an integer-valued reference model.
// Honours BCD_SATURATE_EN so the same bench covers both builds.
module tb_bcd_counter_n;

    localparam int           D    = 4;
    localparam int           MAXV = 9999;
    localparam logic [15:0]  RV   = 16'h0500;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    int   m_val  = 0;
    bit   m_wrap = 1'b0;
    bit   m_err  = 1'b0;
    bit   m_init = 1'b0;
    int   m_wraps = 0;
    int   d_wraps = 0;

    bcd_counter_n_if #(.DIGITS(D)) bus ();

    bcd_counter_n #(.DIGITS(D), .RESET_VAL(RV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic int pow10(input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic bit is_bcd(input logic [15:0] b);
        bit ok = 1'b1;
        for (int i = 0; i < D; i++) begin
            logic [15:0] s;
            s = b >> (4 * i);
            if (s[3:0] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic int bcd2int(input logic [15:0] b);
        int v = 0;
        for (int i = D - 1; i >= 0; i--) begin
            logic [15:0] s;
            s = b >> (4 * i);
            v = v * 10 + int'(s[3:0]);
        end
        return v;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] b = 16'h0000;
        for (int i = 0; i < D; i++) begin
            b = b | (16'((v / pow10(i)) % 10) << (4 * i));
        end
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, check combinational outputs, clock, check registered outputs.
    task automatic cyc(input logic r, input logic l, input logic [15:0] lv,
                       input logic e, input logic ud);
        int          nv;
        bit          nw;
        bit          ne;
        bit          etc;
        logic [2:0]  eena;
        reset        = r;
        bus.load     = l;
        bus.load_val = lv;
        bus.en       = e;
        bus.up_dn    = ud;
        #1;
        etc = ud ? (m_val == MAXV) : (m_val == 0);
        for (int i = 1; i < D; i++) begin
            bit cond;
            cond = ud ? ((m_val % pow10(i)) == pow10(i) - 1) : ((m_val % pow10(i)) == 0);
`ifdef BCD_SATURATE_EN
            eena[i-1] = e & ~l & ~r & cond & ~etc;
`else
            eena[i-1] = e & ~l & ~r & cond;
`endif
        end
        if (m_init) begin
            chk("tc", 32'(bus.tc), 32'(etc));
            chk("ena", 32'(bus.ena), 32'(eena));
        end
        nw = 1'b0;
        ne = 1'b0;
        nv = m_val;
        if (r) begin
            nv = bcd2int(RV);
        end else if (l) begin
            if (is_bcd(lv)) nv = bcd2int(lv);
            ne = !is_bcd(lv);
        end else if (e) begin
`ifdef BCD_SATURATE_EN
            if (!etc) nv = ud ? m_val + 1 : m_val - 1;
`else
            nv = ud ? (m_val + 1) % (MAXV + 1) : (m_val + MAXV) % (MAXV + 1);
            nw = etc;
`endif
        end
        @(posedge clk);
        if (r) m_init = 1'b1;
        m_val  = nv;
        m_wrap = nw;
        m_err  = ne;
        m_wraps += int'(nw);
        #1;
        d_wraps += int'(bus.wrap === 1'b1);
        if (m_init) begin
            chk("q", 32'(bus.q), 32'(int2bcd(m_val)));
            chk("wrap", 32'(bus.wrap), 32'(m_wrap));
            chk("load_err", 32'(bus.load_err), 32'(m_err));
        end
    endtask

    initial begin
        logic [15:0] lv;
        // reset coincident with load: reset wins, no load_err
        cyc(1'b1, 1'b1, 16'h1234, 1'b1, 1'b1);
        chk("reset_q", 32'(bus.q), 32'h0500);
        // hold with en=0
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        chk("hold_q", 32'(bus.q), 32'h0500);
        // full up sweep from 0000
        cyc(1'b0, 1'b1, 16'h0000, 1'b0, 1'b1);
        m_wraps = 0;
        d_wraps = 0;
        for (int i = 0; i < 10000; i++) cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
`ifdef BCD_SATURATE_EN
        chk("sweep_wraps", 32'(d_wraps), 32'd0);
        chk("sweep_end", 32'(bus.q), 32'h9999);
`else
        chk("sweep_wraps", 32'(d_wraps), 32'd1);
        chk("sweep_end", 32'(bus.q), 32'h0000);
`endif
        // down from 0100 with ripple borrows
        cyc(1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        chk("down_0099", 32'(bus.q), 32'h0099);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        chk("down_0098", 32'(bus.q), 32'h0098);
        // down wrap from 0000
        cyc(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        // rejected then accepted load
        cyc(1'b0, 1'b1, 16'h12A4, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 16'h1234, 1'b1, 1'b1);
        chk("load_1234", 32'(bus.q), 32'h1234);
        // approach all-9 counting up
        cyc(1'b0, 1'b1, 16'h9998, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            lv = 16'h0000;
            for (int k = 0; k < D; k++) lv = lv | (16'($urandom_range(0, 9)) << (4 * k));
            if ($urandom_range(0, 3) == 0) lv = lv | (16'($urandom_range(10, 15)) << (4 * $urandom_range(0, D - 1)));
            if ($urandom_range(0, 5) == 0) lv = ($urandom_range(0, 1) == 1) ? 16'h9999 : 16'h0000;
            cyc(1'($urandom_range(0, 99) == 0),
                1'($urandom_range(0, 19) == 0),
                lv,
                1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_counter_n.md
Name: bcd_counter_n

Overview:
Parametrised N-digit synchronous BCD counter with up/down counting, count enable, parallel load and terminal-count/wrap flags. It is the general-purpose decimal counter for display, timer and event-count datapaths. It replaces fixed 4-digit up-only counters. Per-digit ripple enables are exported so downstream logic can cascade or observe individual digit rollovers.

Parameters:
DIGITS, 4, number of BCD digits (1..8); q width is 4*DIGITS
RESET_VAL, 0, reset/clear value as packed BCD (4*DIGITS bits); every nibble must be 0..9

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high; loads RESET_VAL
en  input  1  count enable; one step per cycle while high
up_dn  input  1  1 = count up, 0 = count down; sampled each cycle
load  input  1  synchronous parallel load request
load_val  input  4*DIGITS  packed BCD load value, digit0 in [3:0]
q  output  4*DIGITS  packed BCD count, digit0 in [3:0], registered
ena  output  DIGITS-1  ena[i-1] high when digit i steps this cycle; combinational
tc  output  1  terminal count for current direction; combinational
wrap  output  1  registered one-cycle pulse after an up or down wrap
load_err  output  1  registered one-cycle pulse after a rejected load

Behaviour:
- Priority per cycle: reset > load > en > hold.
- Reset: q=RESET_VAL, wrap=0, load_err=0. ena and tc follow from q.
- Load, all nibbles of load_val <=9: q<=load_val next cycle; wrap=0; load_err=0; en ignored that cycle.
- Load, any nibble >9: q holds; load_err=1 for exactly one cycle; en ignored that cycle. No partial load.
- Count up (en=1, up_dn=1):
  - digit0 increments every cycle; 9->0.
  - Digit i steps when all lower digits ==9: 9->0, else +1.
- Count down (en=1, up_dn=0):
  - digit0 decrements every cycle; 0->9.
  - Digit i steps when all lower digits ==0: 0->9, else -1.
- ena[i-1] = en & !load & !reset & (all digits below i at 9 if up, at 0 if down).
- tc = all digits 9 (up_dn=1) or all digits 0 (up_dn=0). Not gated by en.
- Wrap and load_err:
  - Up wrap: all-9 -> all-0. Down wrap: all-0 -> all-9.
  - On a wrap, the cycle that lands the new value sets wrap=1. wrap=0 on all other cycles.
  - Because wrap and load_err are registered, each is high during the cycle q shows the post-event value.
- up_dn may change on any cycle; the step direction always uses the value sampled at that edge. No hidden state.
- en=0: q holds; ena all 0; tc still valid.
- Reset mid-count or coincident with load: reset wins; load_err is not raised.
- Latency: q updates one cycle after the qualifying edge; no pipeline.
- All digit values stay in 0..9 at all times after reset; an invalid q state is unreachable.

Optional Feature:
Macro BCD_SATURATE_EN.
- Defined: the counter saturates instead of wrapping. At all-9 counting up, or all-0 counting down, q holds. wrap stays 0 and is driven constant 0. ena still reports digit-step conditions gated by !tc, so it is all 0 at saturation.
- Undefined: wrap-around behaviour as specified above.

Test Plan:
- DIGITS=4, reset, en=1 up for 10000 cycles -> q steps 0000..9999 then 0000. wrap high exactly once, on the cycle q=0000. ena[0] high when q[3:0]=9.
- Load 0x0100, up_dn=0, en=1 -> next q=0099, then 0098. ena[0] and ena[1] high on the 0100 cycle.
- q=0000, up_dn=0, en=1 -> tc=1, next q=9999, wrap=1 for one cycle.
- load=1, load_val=0x12A4 -> q unchanged, load_err=1 one cycle. Then load 0x1234 -> q=1234, load_err=0.
- reset=1 and load=1 in the same cycle with RESET_VAL=0x0500 -> q=0500, load_err=0. en=0 for 5 cycles -> q holds 0500, ena=0.
- With BCD_SATURATE_EN, q=9998, up, en=1 for 3 cycles -> 9999, 9999, 9999. wrap stays 0; tc=1.
